interleaver_pp: RTL and testbench
=================================

// Module: interleaver_pp
// PURPOSE
//   Parametrised 802.11a bit interleaver, successor to the fixed 48-bit BPSK block.
//   Supports BPSK/QPSK/16-QAM/64-QAM: N_CBPS = 48/96/192/288, N_BPSC = 1/2/4/6.
//   Uses a ping-pong bit buffer with valid/ready on both sides, sustaining 1 bit/cycle.
//   Sits between the convolutional encoder/puncturer and the constellation mapper.
// PARAMETERS
//   N_COLS      16   interleaver columns; fixed by standard; N_ROWS = N_CBPS/N_COLS
//   N_CBPS_MAX  288  bank depth in bits; sets address width AW = $clog2(N_CBPS_MAX)
// PORTS
//   Clock      in   1  rising-edge clock
//   Reset      in   1  asynchronous, active-high reset
//   in_valid   in   1  in_bit/in_mode valid
//   in_ready   out  1  block accepts bit this cycle (in_valid & in_ready = transfer)
//   in_bit     in   1  coded bit, stream order k = 0..N_CBPS-1
//   in_mode    in   2  0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled on first bit (k=0) only
//   out_valid  out  1  out_bit valid
//   out_ready  in   1  downstream accepts bit
//   out_bit    out  1  interleaved bit, order j = 0..N_CBPS-1
//   out_sof    out  1  high with out_valid on j = 0
//   out_eof    out  1  high with out_valid on j = N_CBPS-1
//   out_mode   out  2  mode of the symbol being drained
// BEHAVIOUR
//   Reset: in_ready=0 for the reset cycle, then 1; out_valid/out_bit/out_sof/out_eof=0;
//     out_mode=0; both banks EMPTY; write counter k=0; read counter j=0. Reset mid-symbol
//     discards all buffered bits.
//   Write: bit k is stored at address j(k) of the write bank; the read side scans addresses
//     sequentially. With s = max(N_BPSC/2,1):
//     i = N_ROWS*(k mod 16) + floor(k/16)
//     j = s*floor(i/s) + (i + N_CBPS - floor(16*i/N_CBPS)) mod s
//     i and j are updated incrementally (row/col counters); no runtime divider.
//   Bank states: EMPTY -> FILLING (first write) -> FULL (k = N_CBPS-1 written)
//     -> DRAINING (bank becomes the read bank) -> EMPTY (j = N_CBPS-1 accepted).
//   Swap: when the write bank is FULL and the read bank is EMPTY, or the read bank's last
//     bit is accepted in the same cycle, the roles swap. No bubble: a back-to-back symbol
//     continues at 1 bit/cycle.
//   in_ready = 0 only while the write bank is FULL and the read bank has not released.
//   Latency: last input bit accepted at cycle t; out_valid with j=0 at t+1 if the read bank
//     is free, otherwise on the cycle after the swap.
//   Output is a registered read; out_bit/out_sof/out_eof/out_mode hold stable while
//     out_valid & !out_ready.
//   in_mode is latched at k=0 and applies to the whole symbol. Changes while k>0 are
//     ignored. in_mode values are all legal.
//   Modes may differ between consecutive symbols; each bank carries its own latched mode.
// CONFIGURATION
//   INTLV_SECOND_PERM_EN defined: full two-step permutation as above.
//   Not defined: j = i (first permutation only); 16-QAM/64-QAM output is then
//     non-compliant, and BPSK/QPSK output is identical in both builds (s=1).
// TESTING
//   BPSK, single 1 at k=1, others 0 -> out_bit=1 only at j=3; k=16 alone -> j=1.
//   QPSK, single 1 at k=1 -> j=6; out_eof at j=95.
//   16-QAM, single 1 at k=1 -> j=13 (SECOND_PERM_EN) / j=12 (not defined).
//   64-QAM, single 1 at k=1 -> j=20 (SECOND_PERM_EN) / j=18 (not defined).
//   Three back-to-back BPSK symbols with out_ready=1 -> in_ready never drops; outputs
//     contiguous, with out_sof every 48 bits. Mixed modes across symbols -> out_mode tracks.
//   out_ready=0 for 300 cycles -> in_ready=0 after 2*N_CBPS writes; no bit lost.
//   Reset asserted at k=20 -> all outputs 0; the next symbol is interleaved correctly.

Source files
------------

// File: rtl/interleaver_pp.sv
// 802.11a bit interleaver (BPSK/QPSK/16-QAM/64-QAM) with a ping-pong bit buffer.
// Define INTLV_SECOND_PERM_EN to enable the second (bit-significance) permutation.
module interleaver_pp #(
  parameter int N_COLS     = 16,
  parameter int N_CBPS_MAX = 288
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic [1:0] in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_sof,
  output logic       out_eof,
  output logic [1:0] out_mode
);

  localparam int AW = $clog2(N_CBPS_MAX);
  localparam int CW = $clog2(N_COLS);

  // Handshake: a bit moves on a side exactly when valid & ready are both high at a
  // rising edge; a source never withdraws valid, and out_* stay frozen while stalled.

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  function automatic logic [AW-1:0] cbps_of(input logic [1:0] mode);
    case (mode)
      2'd0:    cbps_of = AW'(48);
      2'd1:    cbps_of = AW'(96);
      2'd2:    cbps_of = AW'(192);
      default: cbps_of = AW'(288);
    endcase
  endfunction

  function automatic logic [AW-1:0] rows_of(input logic [1:0] mode);
    case (mode)
      2'd0:    rows_of = AW'(48 / N_COLS);
      2'd1:    rows_of = AW'(96 / N_COLS);
      2'd2:    rows_of = AW'(192 / N_COLS);
      default: rows_of = AW'(288 / N_COLS);
    endcase
  endfunction

  bank_state_t           bank_state [2];
  logic [1:0]            bank_mode  [2];
  logic [N_CBPS_MAX-1:0] mem        [2];

  logic          wr_sel;
  logic          rd_sel;
  logic [AW-1:0] wr_k;
  logic [AW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_j;
  logic [AW-1:0] rd_j_nxt;
  logic [1:0]    eff_mode;

  logic in_fire;
  logic out_fire;
  logic wr_last;
  logic wr_done;
  logic rd_last;
  logic rd_free;
  logic swap;

  assign rd_sel   = ~wr_sel;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign rd_j_nxt = rd_j + AW'(1);

  // The mode is taken live on k=0 and from the bank's latched copy afterwards.
  assign eff_mode = (wr_k == '0) ? in_mode : bank_mode[wr_sel];

  assign wr_last = in_fire & (wr_k == cbps_of(eff_mode) - AW'(1));
  assign wr_done = (bank_state[wr_sel] == FULL) | wr_last;
  assign rd_last = out_fire & (rd_j == cbps_of(out_mode) - AW'(1));
  assign rd_free = (bank_state[rd_sel] == EMPTY) | rd_last;
  assign swap    = wr_done & rd_free;

  // i = N_ROWS*col + row, stepped incrementally as k advances.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_k  <= '0;
      col   <= '0;
      row   <= '0;
      i_idx <= '0;
    end else if (in_fire) begin
      if (wr_last) begin
        wr_k  <= '0;
        col   <= '0;
        row   <= '0;
        i_idx <= '0;
      end else begin
        wr_k <= wr_k + AW'(1);
        if (col == CW'(N_COLS - 1)) begin
          col   <= '0;
          row   <= row + AW'(1);
          i_idx <= row + AW'(1);
        end else begin
          col   <= col + CW'(1);
          i_idx <= i_idx + rows_of(eff_mode);
        end
      end
    end
  end

`ifdef INTLV_SECOND_PERM_EN
  // N_ROWS is a multiple of s in every mode, so i mod s == row mod s, and
  // floor(16*i/N_CBPS) == col; both residues are kept as small wrap counters.
  logic [1:0] row_m;
  logic [1:0] col_m;
  logic [1:0] s_val;
  logic [1:0] d_val;

  always_comb begin
    case (eff_mode)
      2'd2:    s_val = 2'd2;
      2'd3:    s_val = 2'd3;
      default: s_val = 2'd1;
    endcase
    d_val   = (row_m >= col_m) ? (row_m - col_m) : (row_m + s_val - col_m);
    wr_addr = i_idx - AW'(row_m) + AW'(d_val);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      row_m <= '0;
      col_m <= '0;
    end else if (in_fire) begin
      if (wr_last) begin
        row_m <= '0;
        col_m <= '0;
      end else if (col == CW'(N_COLS - 1)) begin
        col_m <= '0;
        row_m <= (row_m + 2'd1 == s_val) ? 2'd0 : row_m + 2'd1;
      end else begin
        col_m <= (col_m + 2'd1 == s_val) ? 2'd0 : col_m + 2'd1;
      end
    end
  end
`else
  assign wr_addr = i_idx;
`endif

  always_ff @(posedge Clock) begin
    if (in_fire) begin
      mem[wr_sel][wr_addr] <= in_bit;
    end
  end

  // Bank role control and the registered read port.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      bank_mode[0]  <= 2'd0;
      bank_mode[1]  <= 2'd0;
      wr_sel        <= 1'b0;
      in_ready      <= 1'b0;
      rd_j          <= '0;
      out_valid     <= 1'b0;
      out_bit       <= 1'b0;
      out_sof       <= 1'b0;
      out_eof       <= 1'b0;
      out_mode      <= 2'd0;
    end else begin
      in_ready <= ~(wr_done & ~swap);

      if (in_fire && wr_k == '0) begin
        bank_state[wr_sel] <= FILLING;
        bank_mode[wr_sel]  <= in_mode;
      end

      if (swap) begin
        bank_state[wr_sel] <= DRAINING;
        bank_state[rd_sel] <= EMPTY;
        wr_sel             <= ~wr_sel;
      end else begin
        if (wr_last) begin
          bank_state[wr_sel] <= FULL;
        end
        if (rd_last) begin
          bank_state[rd_sel] <= EMPTY;
        end
      end

      // Address 0 always holds k=0, written long before the swap edge.
      if (swap) begin
        out_valid <= 1'b1;
        rd_j      <= '0;
        out_bit   <= mem[wr_sel][0];
        out_sof   <= 1'b1;
        out_eof   <= 1'b0;
        out_mode  <= bank_mode[wr_sel];
      end else if (out_fire && !rd_last) begin
        rd_j    <= rd_j_nxt;
        out_bit <= mem[rd_sel][rd_j_nxt];
        out_sof <= 1'b0;
        out_eof <= (rd_j_nxt == cbps_of(out_mode) - AW'(1));
      end else if (rd_last) begin
        out_valid <= 1'b0;
        rd_j      <= '0;
        out_bit   <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_pp.sv
// Bench for interleaver_pp: random traffic against a formula-level permutation model,
// plus directed single-bit probes, back-to-back, stall and mid-symbol reset scenarios.
module tb_interleaver_pp;

  logic       Clock     = 1'b0;
  logic       Reset     = 1'b1;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic       in_bit    = 1'b0;
  logic [1:0] in_mode   = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_bit;
  logic       out_sof;
  logic       out_eof;
  logic [1:0] out_mode;

  interleaver_pp dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_mode  (out_mode)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // Expected output entries packed as {mode[1:0], sof, eof, bit}.
  logic [4:0] exp_q[$];
  logic       sym_bits [288];
  logic       out_buf  [288];
  int         cur_k    = 0;
  logic [1:0] cur_mode = 2'd0;

  int rdy_mode    = 0;
  int cyc         = 0;
  int obs_j       = 0;
  int one_pos     = -1;
  int ones_cnt    = 0;
  int eof_pos     = -1;
  int sof_cnt     = 0;
  int first_cyc   = -1;
  int last_cyc    = -1;
  int fire_cnt    = 0;
  int ready_drops = 0;
  logic       prev_hold = 1'b0;
  logic [4:0] prev_out  = '0;

  function automatic int ncbps(input int m);
    case (m)
      0:       return 48;
      1:       return 96;
      2:       return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int perm(input int m, input int k);
    int n;
    int i;
    n = ncbps(m);
    i = (n / 16) * (k % 16) + k / 16;
`ifdef INTLV_SECOND_PERM_EN
    begin
      int s;
      s = (m == 3) ? 3 : ((m == 2) ? 2 : 1);
      return s * (i / s) + (i + n - (16 * i) / n) % s;
    end
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [4:0] e;
    int n;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_eof", out_eof, 0);
        chk("rst_out_mode", out_mode, 0);
        exp_q.delete();
        cur_k     = 0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", {out_mode, out_sof, out_eof, out_bit}, prev_out);
        end
        if (out_valid && out_ready) begin
          fire_cnt++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got bit %0d with nothing expected", out_bit);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {out_mode, out_sof, out_eof, out_bit}, e);
            obs_j = e[2] ? 0 : obs_j + 1;
            if (out_bit) begin
              one_pos = obs_j;
              ones_cnt++;
            end
            if (out_eof) eof_pos = obs_j;
            if (out_sof) sof_cnt++;
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = {out_mode, out_sof, out_eof, out_bit};
        if (in_valid && !in_ready) ready_drops++;
        if (in_valid && in_ready) begin
          if (cur_k == 0) cur_mode = in_mode;
          sym_bits[cur_k] = in_bit;
          cur_k++;
          n = ncbps(cur_mode);
          if (cur_k == n) begin
            for (int k = 0; k < n; k++) out_buf[perm(cur_mode, k)] = sym_bits[k];
            for (int j = 0; j < n; j++)
              exp_q.push_back({cur_mode, (j == 0), (j == n - 1), out_buf[j]});
            cur_k = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 99) < 70);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic drive_accept();
    logic acc;
    int   waited;
    waited = 0;
    do begin
      @(negedge Clock);
      acc = in_ready;
      @(posedge Clock);
      #1;
      waited++;
    end while (!acc && waited < 2000);
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic send_bits(input int mode, input int nbits, input int one_at, input int gap);
    for (int k = 0; k < nbits; k++) begin
      while ($urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
        @(posedge Clock);
        #1;
      end
      in_valid = 1'b1;
      in_bit   = (one_at < 0) ? 1'($urandom_range(0, 1)) : (k == one_at);
      in_mode  = (k == 0) ? 2'(mode) : 2'($urandom_range(0, 3));
      drive_accept();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    @(negedge Clock);
    while ((exp_q.size() != 0 || out_valid || cur_k != 0) && c < 5000) begin
      @(negedge Clock);
      c++;
    end
    if (c >= 5000) fail_now("drain_timeout");
    @(posedge Clock);
    #1;
  endtask

  task automatic probe(input string name, input int mode, input int k, input int exp_j);
    one_pos  = -1;
    ones_cnt = 0;
    send_bits(mode, ncbps(mode), k, 0);
    wait_drain();
    chk(name, one_pos, exp_j);
    chk({name, "_ones"}, ones_cnt, 1);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    int acc;
    int modes[8];
    modes = '{3, 0, 2, 1, 3, 3, 2, 0};

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("ready_after_rst", in_ready, 1);
    @(posedge Clock);
    #1;

    chk("pin_bpsk_k1", perm(0, 1), 3);
    chk("pin_bpsk_k16", perm(0, 16), 1);
    chk("pin_qpsk_k1", perm(1, 1), 6);
`ifdef INTLV_SECOND_PERM_EN
    chk("pin_16qam_k1", perm(2, 1), 13);
    chk("pin_64qam_k1", perm(3, 1), 20);
`else
    chk("pin_16qam_k1", perm(2, 1), 12);
    chk("pin_64qam_k1", perm(3, 1), 18);
`endif

    rdy_mode = 1;
    probe("bpsk_k1", 0, 1, 3);
    probe("bpsk_k16", 0, 16, 1);
    probe("qpsk_k1", 1, 1, 6);
    chk("qpsk_eof_j", eof_pos, 95);
`ifdef INTLV_SECOND_PERM_EN
    probe("qam16_k1", 2, 1, 13);
    probe("qam64_k1", 3, 1, 20);
`else
    probe("qam16_k1", 2, 1, 12);
    probe("qam64_k1", 3, 1, 18);
`endif

    // Back-to-back BPSK at full rate
    rdy_mode = 0;
    @(posedge Clock);
    #1;
    first_cyc   = -1;
    sof_cnt     = 0;
    ready_drops = 0;
    for (int s = 0; s < 3; s++) send_bits(0, 48, -1, 0);
    wait_drain();
    chk("b2b_span", last_cyc - first_cyc, 143);
    chk("b2b_sof_cnt", sof_cnt, 3);
    chk("b2b_ready_drops", ready_drops, 0);

    // Mixed modes with random gaps and backpressure
    rdy_mode = 1;
    for (int s = 0; s < 8; s++) send_bits(modes[s], ncbps(modes[s]), -1, 20);
    for (int s = 0; s < 6; s++) begin
      int m;
      m = $urandom_range(0, 3);
      send_bits(m, ncbps(m), -1, 10);
    end
    wait_drain();

    // Sink stalled for 300 cycles
    rdy_mode = 2;
    @(posedge Clock);
    #1;
    acc = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      in_mode  = 2'd0;
      @(negedge Clock);
      if (in_ready) acc++;
      @(posedge Clock);
      #1;
    end
    in_valid = 1'b0;
    @(negedge Clock);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_writes", acc, 96);
    @(posedge Clock);
    #1;
    fire_cnt = 0;
    rdy_mode = 1;
    wait_drain();
    chk("stall_drained", fire_cnt, 96);

    // Reset in the middle of a 64-QAM symbol
    send_bits(3, 20, -1, 0);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(posedge Clock);
    #1;
`ifdef INTLV_SECOND_PERM_EN
    probe("post_rst_qam16", 2, 1, 13);
`else
    probe("post_rst_qam16", 2, 1, 12);
`endif
    send_bits(1, 96, -1, 15);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
